// File: rtl/dist_ram_pkg.sv
// Shared types and constants for the clearable distributed RAM.
package dist_ram_pkg;

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam int DATA_W_MIN = 1;
  localparam int DATA_W_MAX = 32;
  localparam int ADDR_W_MIN = 1;
  localparam int ADDR_W_MAX = 8;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/dist_ram_core.sv
// Plain storage array: synchronous write, asynchronous read, no reset.
import dist_ram_pkg::*;

module dist_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dist_ram_clr.sv
// Single-port distributed RAM with a clear sequencer that sweeps every word
// to INIT_VAL after reset and on request.
import dist_ram_pkg::*;

module dist_ram_clr #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0,
  parameter int                 READ_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              clear_req,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              wr_drop
);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              wr_drop_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;

  assign busy    = (state_q == CLEAR);
  assign wr_drop = wr_drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= busy & we;
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
          end
        end
        CLEAR: begin
          // Pointer wraps to 0 naturally on the last write.
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (&clr_ptr_q) state_q <= IDLE;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // The sweep owns the write port; user writes are discarded while it runs.
  always_comb begin
    mem_we    = we;
    mem_waddr = addr;
    mem_wdata = din;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = INIT_VAL;
    end
  end

  dist_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (addr),
    .rdata_o (rdata)
  );

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] dout_q;
      // Read-first: samples the array before this edge's write lands.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)     dout_q <= INIT_VAL;
        else if (busy) dout_q <= INIT_VAL;
        else           dout_q <= rdata;
      end
      assign dout = busy ? INIT_VAL : dout_q;
    end else begin : g_rd_async
      assign dout = busy ? INIT_VAL : rdata;
    end
  endgenerate

endmodule

// File: doc/dist_ram_clr.md
# dist_ram_clr

Parametrised single-port distributed RAM: synchronous write, asynchronous or registered read, configurable width and depth. It adds a hardware clear sequencer that sweeps every location to `INIT_VAL` after reset and on request, so contents are defined without a global-set/reset of the array. It is used as register-file and scratchpad storage beside the processor core, replacing hand-instantiated 16x1 cells.

## Interface
- `DATA_W`, default 8: word width in bits, 1..32.
- `ADDR_W`, default 4: address width. `DEPTH = 2**ADDR_W`, 2..256.
- `INIT_VAL`, default 0: `DATA_W`-bit value written by the clear sweep.
- `READ_REG`, default 0: 0 selects asynchronous read; 1 selects registered read with 1-cycle latency.
- `clk` input 1: single clock. All writes and state updates occur on the rising edge.
- `reset` input 1: asynchronous, active-high. Forces the block into `CLEAR` with the pointer at 0.
- `addr` input `ADDR_W`: read/write address.
- `din` input `DATA_W`: write data.
- `we` input 1: write enable, sampled on the `clk` rising edge.
- `clear_req` input 1: one-cycle request to re-clear the whole array.
- `dout` output `DATA_W`: read data.
- `busy` output 1: high while the clear sweep is running.
- `wr_drop` output 1: registered pulse, high for one cycle when a user write was discarded because the sweep was running.

## Operation
- FSM with two states, `IDLE` and `CLEAR`.
- `reset` asserted:
  - state goes to `CLEAR`, `clr_ptr` to 0, `busy` to 1, `wr_drop` to 0.
  - If `READ_REG=1`, the `dout` register goes to `INIT_VAL`.
  - Array contents are not touched by reset.
- `CLEAR` state:
  - Each edge writes `INIT_VAL` to `clr_ptr`, then increments `clr_ptr`.
  - On the edge that writes `DEPTH-1`, the FSM moves to `IDLE` and `clr_ptr` wraps to 0.
- `IDLE` state:
  - `we=1` writes `din` to `mem[addr]`.
  - `clear_req=1` moves the FSM to `CLEAR` with `clr_ptr=0`.
  - If `we` and `clear_req` are both high on the same edge, the user write is performed and the sweep then starts. The written word is overwritten during the sweep.
- User writes while busy:
  - `we=1` while in `CLEAR` is discarded.
  - `wr_drop` is 1 on the following cycle.
  - A `clear_req` in `CLEAR` is ignored; the sweep does not restart.
- Read path:
  - While `busy=1`, `dout` is forced to `INIT_VAL` in both read modes.
  - `READ_REG=0`: `dout = mem[addr]`, combinational in `addr`. A same-address write becomes visible right after the write edge.
  - `READ_REG=1`: `dout` register loads `mem[addr]` on each edge while `IDLE`. This is read-first: a same-address write on that edge returns the old data, and the new data appears one edge later.
- Width rules:
  - `clr_ptr` is `ADDR_W` bits and wraps naturally.
  - `din`, `dout` and `INIT_VAL` are all exactly `DATA_W` bits; nothing is truncated or extended.

## Timing
- Reset values:
  - `busy=1`, `wr_drop=0`.
  - `dout=INIT_VAL`: forced by `busy` when `READ_REG=0`, held by the register when `READ_REG=1`.
- After `reset` deassertion:
  - The first rising edge writes address 0.
  - `busy` stays high for exactly `DEPTH` edges and falls after the edge that writes `DEPTH-1`.
- `clear_req` sampled in `IDLE` at edge N:
  - `busy` rises after edge N.
  - Addresses 0..`DEPTH-1` are written at edges N+1..N+`DEPTH`.
  - `busy` falls after edge N+`DEPTH`.
- The first user write is accepted on the first edge where `busy=0`.
- Reset asserted mid-sweep: `busy` stays 1, `clr_ptr` returns to 0 immediately, and a full sweep runs again after release.
- Write latency is 0: data is stored at the edge.
- Read latency:
  - `READ_REG=0`: combinational.
  - `READ_REG=1`: 1 cycle from `addr` to `dout`.

## Structure
- Shared package `dist_ram_pkg` holds:
  - the state enum `{IDLE, CLEAR}`;
  - the `ADDR_W`/`DATA_W` legal range constants;
  - a function computing `DEPTH` from `ADDR_W`.
- Sub-module `dist_ram_core`:
  - plain array with synchronous write and asynchronous read, no reset;
  - parametrised by `DATA_W` and `ADDR_W`.
- Top level contains:
  - the FSM and `clr_ptr`;
  - the write-port mux (sweep or user);
  - the `wr_drop` flop;
  - the optional `dout` register, generated by `READ_REG`.

## Test plan
- **Reset sweep.** `DATA_W=8`, `ADDR_W=4`, `INIT_VAL=8'hA5`; pulse `reset` and release.
  - `busy` is high for exactly 16 edges.
  - Afterwards, reads of all 16 addresses return `8'hA5`.
- **Basic write/read.** Write `8'h3C` at address 7, then read address 7.
  - `READ_REG=0`: `dout=8'h3C` right after the write edge.
  - `READ_REG=1`: `dout=8'h3C` one edge later.
- **Write during sweep.** Assert `we` with address 2 and `din=8'hFF` on the third sweep cycle.
  - `wr_drop` pulses for one cycle.
  - Address 2 reads `8'hA5` after `busy` falls.
- **Coincident write and clear.** In `IDLE`, assert `clear_req` and `we` (address 5, `8'h11`) together.
  - The sweep starts on the next cycle.
  - After 16 edges, address 5 reads `8'hA5`.
  - `wr_drop` stays 0.
- **Reset mid-sweep.** Start a sweep, then assert `reset` at `clr_ptr=9`.
  - `busy` stays 1.
  - After release, a full 16-edge sweep runs and all addresses read `8'hA5`.
- **Read-first collision.** `READ_REG=1`: write `8'h42` to an address holding `8'h10` while reading the same address.
  - `dout` shows `8'h10` after that edge.
  - `dout` shows `8'h42` after the next edge.
